// File: rtl/i2c_reg_pkg.sv
// Shared definitions for the I2C register arbiter: local FSM encoding,
// fixed decode constants and the default write-unlock key.
// Imported by every file in the i2c_reg_arbiter slice.
package i2c_reg_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACK  = 1'b1
   } loc_state_t;

   localparam logic [7:0] ADDR_ID        = 8'h00;
   localparam logic [7:0] OOR_READ_VAL   = 8'hFF;
   localparam logic [7:0] DEF_UNLOCK_KEY = 8'hA5;

endpackage

// File: rtl/i2c_reg_evt_status.sv
// Sticky write-1-to-clear event status register with rising-edge capture.
// Latency: a status bit sets at the first clock that sees the new level; irq follows one cycle later.
// Backpressure: none. Set wins over a same-cycle clear of the same bit.
module i2c_reg_evt_status
   import i2c_reg_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] evt_in,
   input  logic [7:0] clr,
   output logic [7:0] status,
   output logic       irq
);

   logic [7:0] evt_q;
   logic [7:0] evt_rise;

   assign evt_rise = evt_in & ~evt_q;

   // Edge history, sticky status (set applied after clear so set wins), registered irq.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_q  <= '0;
         status <= '0;
         irq    <= 1'b0;
      end else begin
         evt_q  <= evt_in;
         status <= (status & ~clr) | evt_rise;
         irq    <= |status;
      end
   end

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Register bank shared by the I2C slave (always first) and one local 4-phase requester.
// Latency: I2C read combinational, I2C write 1 cycle, local grant 1 cycle after request when no I2C write strobe.
// Backpressure: I2C never stalls; a local access slips whole cycles while i2c_wr_data_vld is high.
// Optional: I2C_REG_WR_UNLOCK_EN gates I2C writes behind an unlock key written to LOCK_ADDR.
module i2c_reg_arbiter
   import i2c_reg_pkg::*;
#(
   parameter int          REG_NUM    = 16,
   parameter logic [7:0]  ID_VALUE   = 8'h42,
   parameter logic [7:0]  STAT_ADDR  = 8'h01,
   parameter logic [15:0] RO_MASK    = 16'h0001,
   parameter logic [7:0]  UNLOCK_KEY = DEF_UNLOCK_KEY,
   parameter logic [7:0]  LOCK_ADDR  = 8'h0F
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] i2c_word_addr,
   input  logic       i2c_word_addr_vld,
   input  logic [7:0] i2c_wr_data,
   input  logic       i2c_wr_data_vld,
   input  logic       i2c_send,
   output logic [7:0] i2c_rd_data,
   input  logic       loc_req,
   input  logic       loc_we,
   input  logic [7:0] loc_addr,
   input  logic [7:0] loc_wdata,
   output logic       loc_gnt,
   output logic [7:0] loc_rdata,
   input  logic [7:0] evt_in,
   output logic       irq
);

   loc_state_t state, state_nxt;
   logic [7:0] bank [256];
   logic [7:0] status;
   logic [7:0] stat_clr;
   logic [7:0] rd_shadow;
   logic [7:0] i2c_rd_val;
   logic [7:0] loc_rd_val;
   logic       i2c_we;
   logic       loc_exec;
   logic       loc_wr;
`ifdef I2C_REG_WR_UNLOCK_EN
   logic       unlocked;
`endif

   function automatic logic in_range(input logic [7:0] a);
      return 32'(a) < REG_NUM;
   endfunction

   function automatic logic is_ro(input logic [7:0] a);
      return (a[7:4] == 4'h0) && RO_MASK[a[3:0]];
   endfunction

   // Shared read decode: ID, out-of-range, status, optional lock flag, then the bank.
   function automatic logic [7:0] rd_decode(input logic [7:0] a);
      logic [7:0] v;
      if (a == ADDR_ID)          v = ID_VALUE;
      else if (!in_range(a))     v = OOR_READ_VAL;
      else if (a == STAT_ADDR)   v = status;
`ifdef I2C_REG_WR_UNLOCK_EN
      else if (a == LOCK_ADDR)   v = {7'b0, unlocked};
`endif
      else                       v = bank[a];
      return v;
   endfunction

   assign i2c_rd_val  = rd_decode(i2c_word_addr);
   assign loc_rd_val  = rd_decode(loc_addr);
   assign i2c_rd_data = i2c_word_addr_vld ? i2c_rd_val : rd_shadow;
   assign loc_wr      = loc_exec && loc_we && (loc_addr != ADDR_ID) && in_range(loc_addr);

   // I2C write qualification: address 0, out-of-range, RO_MASK and (optionally) the lock.
   always_comb begin
      i2c_we = i2c_wr_data_vld && (i2c_word_addr != ADDR_ID) &&
               in_range(i2c_word_addr) && !is_ro(i2c_word_addr);
`ifdef I2C_REG_WR_UNLOCK_EN
      if (!unlocked && (i2c_word_addr != LOCK_ADDR) && (i2c_word_addr != STAT_ADDR))
         i2c_we = 1'b0;
`endif
   end

   // W1C clear mask for the status register; I2C and local writes never coincide.
   always_comb begin
      stat_clr = '0;
      if (i2c_we && (i2c_word_addr == STAT_ADDR))
         stat_clr = i2c_wr_data;
      else if (loc_wr && (loc_addr == STAT_ADDR))
         stat_clr = loc_wdata;
   end

   // Bank storage: I2C write has precedence, local write only lands in strobe-free cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) bank[i] <= '0;
      end else if (i2c_we) begin
         bank[i2c_word_addr] <= i2c_wr_data;
      end else if (loc_wr) begin
         bank[loc_addr] <= loc_wdata;
      end
   end

   // Read shadow: tracks the addressed value except while a byte is being shifted out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                              rd_shadow <= '0;
      else if (i2c_word_addr_vld || !i2c_send) rd_shadow <= i2c_rd_val;
   end

`ifdef I2C_REG_WR_UNLOCK_EN
   // Unlock flag: key written to LOCK_ADDR opens I2C writes, any other value closes them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  unlocked <= 1'b0;
      else if (i2c_we && (i2c_word_addr == LOCK_ADDR)) unlocked <= (i2c_wr_data == UNLOCK_KEY);
   end
`endif

   // Local FSM state register plus registered grant and read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         loc_gnt   <= 1'b0;
         loc_rdata <= '0;
      end else begin
         state   <= state_nxt;
         loc_gnt <= (state_nxt == ST_ACK);
         if (loc_exec && !loc_we) loc_rdata <= loc_rd_val;
      end
   end

   // Local FSM next state: execute in IDLE only when no I2C write strobe competes.
   always_comb begin
      state_nxt = state;
      loc_exec  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (loc_req && !i2c_wr_data_vld) begin
               loc_exec  = 1'b1;
               state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!loc_req) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   i2c_reg_evt_status u_evt_status (
      .clk    (clk),
      .rst_n  (rst_n),
      .evt_in (evt_in),
      .clr    (stat_clr),
      .status (status),
      .irq    (irq)
   );

endmodule

// File: doc/i2c_reg_arbiter.md
Name: i2c_reg_arbiter

Overview:
- Owns the CPLD 8-bit register bank behind the I2C slave register port.
- Shares the bank between the I2C slave (word address, write data, read data) and one local CPLD logic requester.
- I2C always has priority. The I2C read path has zero-cycle latency, and the byte being shifted out is held stable.
- Also implements a read-only ID register and a sticky write-1-to-clear event status register.

Parameters:
REG_NUM, 16, number of implemented registers at addresses 0..REG_NUM-1 (max 256)
ID_VALUE, 8'h42, constant value returned at address 0
STAT_ADDR, 8'h01, address of the sticky W1C event status register
RO_MASK, 16'h0001, bit i=1 makes address i read-only from I2C (local writes still allowed, except to address 0)
UNLOCK_KEY, 8'hA5, key for the optional write unlock
LOCK_ADDR, 8'h0F, address of the optional unlock register

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i2c_word_addr  in  8  current register address from the I2C slave
i2c_word_addr_vld  in  1  one-cycle strobe: address loaded or auto-incremented
i2c_wr_data  in  8  I2C write byte
i2c_wr_data_vld  in  1  one-cycle strobe: write i2c_wr_data to i2c_word_addr
i2c_send  in  1  slave is driving SDA (read byte in progress)
i2c_rd_data  out  8  read byte presented to the I2C slave
loc_req  in  1  local access request (4-phase)
loc_we  in  1  1=write, 0=read; stable while loc_req=1
loc_addr  in  8  local address; stable while loc_req=1
loc_wdata  in  8  local write data
loc_gnt  out  1  access done; held until loc_req falls
loc_rdata  out  8  local read data, valid while loc_gnt=1
evt_in  in  8  hardware event inputs, already synchronous
irq  out  1  OR of the status register bits

Behaviour:
- Reset (asynchronous): all registers 0; rd_shadow=0; loc_gnt=0; loc_rdata=0; FSM=IDLE; irq=0; evt edge history=0.
- Address decode:
  - addr 0 reads ID_VALUE; writes to it are always ignored.
  - addr >= REG_NUM reads 8'hFF; writes to it are ignored.
- I2C read path:
  - i2c_rd_data = i2c_word_addr_vld ? bank[i2c_word_addr] (combinational) : rd_shadow.
  - rd_shadow loads bank[i2c_word_addr] on every cycle with i2c_word_addr_vld=1 or i2c_send=0.
  - While i2c_send=1 with no vld, rd_shadow is frozen, so local writes cannot corrupt a byte in flight.
- I2C write: on i2c_wr_data_vld, bank[i2c_word_addr] <= i2c_wr_data at the next edge, unless RO_MASK bit is set or the address is out of range. No stall; I2C is never blocked.
- STAT_ADDR register:
  - Bit i is set on a rising edge of evt_in[i] (registered edge detect, so set occurs 1 cycle after the edge).
  - Writes (I2C or local) clear the bits written as 1.
  - If set and clear hit the same bit in the same cycle, set wins.
  - irq is registered: |status, one cycle after a status change.
- Local FSM states: IDLE, ACK.
  - IDLE -> ACK when loc_req=1 and i2c_wr_data_vld=0 in the same cycle. At that edge the access executes: write to the bank, or loc_rdata <= decoded read value.
  - If i2c_wr_data_vld=1 in that cycle, the local access is deferred by whole cycles until a strobe-free cycle. Consequence: on a same-address collision the local value lands last.
  - ACK: loc_gnt=1. ACK -> IDLE when loc_req=0. loc_gnt is registered and falls the cycle after loc_req falls.
  - A new request is accepted no earlier than the cycle after returning to IDLE.
  - Local writes honour the address 0 and out-of-range rules but ignore RO_MASK.
- Latency: local access grant appears 1 cycle after loc_req with no I2C contention. I2C read is combinational; I2C write takes 1 cycle.
- loc_req dropping in IDLE before it is granted: no access occurs.

Optional Feature:
- Macro: I2C_REG_WR_UNLOCK_EN.
- When defined:
  - I2C writes to any address other than LOCK_ADDR and STAT_ADDR are dropped unless the unlocked flag is 1.
  - An I2C write of UNLOCK_KEY to LOCK_ADDR sets the flag; any other value written there clears it.
  - Reading LOCK_ADDR returns {7'b0, unlocked}.
  - Reset clears the flag.
  - The local port is unaffected.
- When undefined: LOCK_ADDR is an ordinary register and all I2C writes follow RO_MASK only.

Decomposition:
- Shared package i2c_reg_pkg holds:
  - FSM state encoding (IDLE=1'b0, ACK=1'b1)
  - ADDR_ID=8'h00
  - OOR_READ_VAL=8'hFF
  - default UNLOCK_KEY
- One natural sub-module: i2c_reg_evt_status (edge detect, sticky W1C register, set-wins priority, irq). The bank, read mux and FSM stay in the top module.

Test Plan:
- I2C write addr 8'h05 = 8'h3C, then I2C read of addr 5 -> i2c_rd_data=8'h3C in the vld cycle; addr 0 reads 8'h42; addr 8'h20 reads 8'hFF.
- I2C write 8'h11 to addr 0 (RO) -> ignored, reads 8'h42. Local write 8'h77 to addr 0 -> ignored. Local write 8'h77 to addr 2 -> loc_gnt 1 cycle after loc_req; reads back 8'h77.
- With i2c_send=1 and addr 3 shadowed as 8'hAA, local writes 8'h55 to addr 3 -> i2c_rd_data stays 8'hAA until i2c_send falls, then 8'h55.
- i2c_wr_data_vld and loc_req (write, same addr 4) in the same cycle -> I2C writes first, local grant 1 cycle later, final bank[4]=local data.
- evt_in[2] rises -> status=8'h04 and irq=1; I2C write 8'h04 to STAT_ADDR in the same cycle as a new evt_in[2] edge -> bit stays 1. A later clear with no edge -> 0, irq falls 1 cycle later.
- With I2C_REG_WR_UNLOCK_EN defined: I2C write to addr 6 is dropped. Write 8'hA5 to LOCK_ADDR, then to addr 6 -> accepted; write 8'h00 to LOCK_ADDR -> relocked.
